// File: rtl/ldpc_extrinsic_accumulator.sv
// Leave-one-out saturating accumulator for LDPC node updates: three-stage
// pipeline (register lanes, full-precision total, per-lane subtract + clamp).
module ldpc_extrinsic_accumulator #(
  parameter int unsigned NUM_INPUTS = 6,
  parameter int unsigned WIDTH      = 16,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [NUM_INPUTS*WIDTH-1:0]   i_in_data,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [NUM_INPUTS*WIDTH-1:0]   o_out_data,
  output logic [WIDTH-1:0]              o_out_total,
  output logic [NUM_INPUTS-1:0]         o_out_sat
);

  // Guard bits: clog2 for the N-way sum plus one so subtraction never wraps.
  localparam int unsigned GW = WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int unsigned DW = NUM_INPUTS * WIDTH;

  typedef logic signed [GW-1:0] wide_t;

  logic                  advance;
  logic                  s1_valid;
  logic [DW-1:0]         s1_data;
  logic                  s2_valid;
  wide_t                 s2_total;
  wide_t                 s2_lane [NUM_INPUTS];

  wide_t                 s1_ext_c [NUM_INPUTS];
  wide_t                 s1_sum_c;
  logic [DW-1:0]         s3_data_c;
  logic [WIDTH-1:0]      s3_total_c;
  logic [NUM_INPUTS-1:0] s3_sat_c;

  // Zero- or sign-extend one lane into the guard-bit domain.
  function automatic wide_t extend(input logic [WIDTH-1:0] v);
    logic fill;
    fill = SIGNED ? v[WIDTH-1] : 1'b0;
    return {{(GW-WIDTH){fill}}, v};
  endfunction

  // True when v lies outside the representable output range.
  function automatic logic sat_clip(input wide_t v);
    logic clip;
    if (SIGNED) begin
      clip = (v[GW-1:WIDTH-1] != '0) && (v[GW-1:WIDTH-1] != '1);
    end else begin
      clip = (v[GW-1:WIDTH] != '0);
    end
    return clip;
  endfunction

  // Clamp v to the output range; in-range values pass through unchanged.
  function automatic logic [WIDTH-1:0] sat_value(input wide_t v);
    logic [WIDTH-1:0] res;
    res = v[WIDTH-1:0];
    if (sat_clip(v)) begin
      if (SIGNED) begin
        res = v[GW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        res = v[GW-1] ? '0 : '1;
      end
    end
    return res;
  endfunction

  // Single global enable: the whole pipe moves or the whole pipe holds.
  assign advance    = !o_out_valid || i_out_ready;
  assign o_in_ready = advance;

  // Stage-2 input: extended lanes and their full-precision total.
  always_comb begin
    s1_sum_c = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      s1_ext_c[k] = extend(s1_data[k*WIDTH +: WIDTH]);
      s1_sum_c    = s1_sum_c + s1_ext_c[k];
    end
  end

  // Stage-3 input: leave-one-out differences, clamped, with clip flags.
  always_comb begin
    s3_data_c  = '0;
    s3_sat_c   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      s3_data_c[k*WIDTH +: WIDTH] = sat_value(s2_total - s2_lane[k]);
      s3_sat_c[k]                 = sat_clip(s2_total - s2_lane[k]);
    end
    s3_total_c = sat_value(s2_total);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s2_valid    <= 1'b0;
      s2_total    <= '0;
      s2_lane     <= '{default: '0};
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_total <= '0;
      o_out_sat   <= '0;
    end else if (advance) begin
      s1_valid    <= i_in_valid && o_in_ready;
      if (i_in_valid) begin
        s1_data   <= i_in_data;
      end
      s2_valid    <= s1_valid;
      s2_total    <= s1_sum_c;
      s2_lane     <= s1_ext_c;
      o_out_valid <= s2_valid;
      o_out_data  <= s3_data_c;
      o_out_total <= s3_total_c;
      o_out_sat   <= s3_sat_c;
    end
  end

  // Elaboration-range check for simulation only.
  always_ff @(posedge i_clock) begin
    assert (NUM_INPUTS >= 2 && NUM_INPUTS <= 16 && WIDTH >= 2 && WIDTH <= 32)
      else $error("ldpc_extrinsic_accumulator: illegal NUM_INPUTS/WIDTH");
  end

endmodule

// File: tb/tb_ldpc_extrinsic_accumulator.sv
// Multi-configuration bench: directed table vectors, latency/reset sequences,
// backpressure and random traffic, all checked through a per-instance scoreboard.
module tb_ldpc_extrinsic_accumulator;

  localparam int NCFG  = 15;
  localparam int NVEC  = 6;
  localparam int NBP   = 10;
  localparam int NRAND = 670;

  typedef struct {
    logic [511:0] d;
    logic [31:0]  t;
    logic [15:0]  s;
  } exp_t;

  typedef struct {
    int                cfg;
    logic [15:0][31:0] lane;
    logic [15:0][31:0] el;
    logic [31:0]       et;
    logic [15:0]       es;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_glob_n = 1'b1;
  int              n_cmp = 0;
  int              n_fail = 0;
  logic [NCFG-1:0] done_vec;
  vec_t            tbl [NVEC];

  always #5 clk = ~clk;

  function automatic int cfg_n(int g);
    if (g == 0) return 6;
    if (g == 1) return 3;
    if (g == 2) return 4;
    if (g < 7)  return 2;
    if (g < 11) return 5;
    return 16;
  endfunction

  function automatic int cfg_w(int g);
    if (g < 2)  return 16;
    if (g == 2) return 8;
    return (((g - 3) % 4) < 2) ? 4 : 16;
  endfunction

  function automatic bit cfg_s(int g);
    if (g < 2)  return 1'b0;
    if (g == 2) return 1'b1;
    return ((g - 3) % 2) == 1;
  endfunction

  task automatic chk(input string nm, input int g, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: actual %0h required %0h", g, nm, got, exp);
    end
  endtask

  function automatic logic [511:0] pack(int n, int w, logic [15:0][31:0] v);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < w; b++) r[k*w+b] = v[k][b];
    return r;
  endfunction

  function automatic logic [31:0] trunc(int w, logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < w; b++) r[b] = v[b];
    return r;
  endfunction

  // Reference: wide-integer leave-one-out sum with clamp.
  function automatic exp_t model(int n, int w, bit sg, logic [511:0] d);
    exp_t   r;
    longint v [16];
    longint tot, e, mx, mn;
    r.d = '0; r.t = '0; r.s = '0; tot = 0;
    mx = sg ? (longint'(1) <<< (w - 1)) - 1 : (longint'(1) <<< w) - 1;
    mn = sg ? -(longint'(1) <<< (w - 1)) : 0;
    for (int k = 0; k < n; k++) begin
      v[k] = 0;
      for (int b = 0; b < w; b++) v[k][b] = d[k*w+b];
      if (sg && v[k][w-1]) v[k] = v[k] - (longint'(1) <<< w);
      tot += v[k];
    end
    for (int k = 0; k < n; k++) begin
      e = tot - v[k];
      if (e > mx) begin e = mx; r.s[k] = 1'b1; end
      else if (e < mn) begin e = mn; r.s[k] = 1'b1; end
      for (int b = 0; b < w; b++) r.d[k*w+b] = e[b];
    end
    e = tot;
    if (e > mx) e = mx;
    else if (e < mn) e = mn;
    for (int b = 0; b < w; b++) r.t[b] = e[b];
    return r;
  endfunction

  // Random lanes biased towards the range extremes to provoke clipping.
  function automatic logic [511:0] rand_beat(int n, int w, bit sg);
    logic [511:0] r;
    logic [31:0]  v;
    r = '0;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = '1;
        2:       v = sg ? (32'h7FFF_FFFF >> (32 - w)) : '1;
        default: v = sg ? (32'h1 << (w - 1)) : '0;
      endcase
      for (int b = 0; b < w; b++) r[k*w+b] = v[b];
    end
    return r;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int N = cfg_n(g);
    localparam int W = cfg_w(g);
    localparam bit S = cfg_s(g);

    logic           rst_loc = 1'b1;
    logic           dut_rst_n;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [N*W-1:0] out_data;
    logic [W-1:0]   out_total;
    logic [N-1:0]   out_sat;
    int             mode = 0;
    exp_t           cur_exp;
    exp_t           q [$];
    bit             done = 1'b0;

    assign dut_rst_n   = rst_glob_n & rst_loc;
    assign done_vec[g] = done;

    ldpc_extrinsic_accumulator #(.NUM_INPUTS(N), .WIDTH(W), .SIGNED(S)) dut (
      .i_clock    (clk),
      .i_reset_n  (dut_rst_n),
      .i_in_valid (in_valid),
      .o_in_ready (in_ready),
      .i_in_data  (in_data),
      .o_out_valid(out_valid),
      .i_out_ready(out_ready),
      .o_out_data (out_data),
      .o_out_total(out_total),
      .o_out_sat  (out_sat)
    );

    // Scoreboard: head of queue must sit on the output for as long as it is valid.
    always @(negedge clk) begin
      if (dut_rst_n) begin
        chk("in_ready", g, 512'(in_ready), 512'(!out_valid || out_ready));
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", g, 512'(out_valid), 512'(1'b0));
          end else begin
            chk("data",  g, 512'(out_data),  q[0].d);
            chk("total", g, 512'(out_total), 512'(q[0].t));
            chk("sat",   g, 512'(out_sat),   512'(q[0].s));
            if (out_ready) void'(q.pop_front());
          end
        end
        if (in_valid && in_ready) q.push_back(cur_exp);
      end
    end

    initial begin
      int ph = 0;
      forever begin
        @(posedge clk); #1;
        if (mode == 1) begin
          out_ready = (ph == 0) || (ph == 3);
          ph = (ph + 1) % 4;
        end else if (mode == 2) begin
          out_ready = 1'($urandom_range(0, 1));
        end else begin
          out_ready = 1'b1;
        end
      end
    end

    task automatic send(input logic [511:0] d, input exp_t e);
      bit acc;
      int guard;
      cur_exp  = e;
      in_data  = d[N*W-1:0];
      in_valid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 1000) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1; guard++;
      end
      if (!acc) chk("accept_timeout", g, 512'(acc), 512'(1'b1));
      in_valid = 1'b0;
    endtask

    // Empty pipe, ready high: valid must rise on the second edge after acceptance.
    task automatic latency_beat(input logic [511:0] d, input exp_t e);
      cur_exp  = e;
      in_data  = d[N*W-1:0];
      in_valid = 1'b1;
      @(negedge clk); chk("ready_when_empty", g, 512'(in_ready), 512'(1'b1));
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1; chk("latency_edge1", g, 512'(out_valid), 512'(1'b0));
      @(posedge clk); #1; chk("latency_edge2", g, 512'(out_valid), 512'(1'b1));
    endtask

    task automatic drain();
      int c = 0;
      while ((q.size() != 0 || out_valid) && c < 500) begin
        @(posedge clk); #1; c++;
      end
      chk("drain", g, 512'(q.size()), 512'(0));
    endtask

    initial begin
      logic [511:0] d;
      exp_t         e;
      @(negedge clk);
      chk("reset_valid", g, 512'(out_valid), 512'(0));
      chk("reset_data",  g, 512'(out_data),  512'(0));
      chk("reset_total", g, 512'(out_total), 512'(0));
      chk("reset_sat",   g, 512'(out_sat),   512'(0));
      wait (rst_glob_n);
      @(posedge clk); #1;

      for (int i = 0; i < NVEC; i++) begin
        if (tbl[i].cfg == g) begin
          d   = pack(N, W, tbl[i].lane);
          e.d = pack(N, W, tbl[i].el);
          e.t = trunc(W, tbl[i].et);
          e.s = tbl[i].es;
          if (g == 0) latency_beat(d, e);
          else send(d, e);
        end
      end
      drain();

      if (g == 0) begin
        for (int i = 0; i < 3; i++) begin
          d = rand_beat(N, W, S);
          send(d, model(N, W, S, d));
        end
        chk("three_in_flight", g, 512'(out_valid), 512'(1'b1));
        #2 rst_loc = 1'b0;
        #1;
        chk("midreset_valid", g, 512'(out_valid), 512'(0));
        chk("midreset_data",  g, 512'(out_data),  512'(0));
        chk("midreset_total", g, 512'(out_total), 512'(0));
        chk("midreset_sat",   g, 512'(out_sat),   512'(0));
        q.delete();
        repeat (2) @(posedge clk);
        #3 rst_loc = 1'b1;
        repeat (6) begin
          @(negedge clk); chk("no_stale_beat", g, 512'(out_valid), 512'(0));
        end
        @(posedge clk); #1;
        d = rand_beat(N, W, S);
        latency_beat(d, model(N, W, S, d));
        drain();
      end

      mode = 1;
      for (int i = 0; i < NBP; i++) begin
        d = rand_beat(N, W, S);
        send(d, model(N, W, S, d));
      end
      drain();

      mode = 2;
      for (int i = 0; i < NRAND; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        end
        d = rand_beat(N, W, S);
        send(d, model(N, W, S, d));
      end
      drain();
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].lane = '0; tbl[i].el = '0; tbl[i].et = '0; tbl[i].es = '0;
    end
    tbl[0].cfg = 0;
    for (int k = 0; k < 6; k++) begin
      tbl[0].lane[k] = 32'(k + 1);
      tbl[0].el[k]   = 32'(20 - k);
    end
    tbl[0].et = 32'd21; tbl[0].es = 16'h0;

    tbl[1].cfg = 1;
    tbl[1].lane[0] = 32'hFFFF; tbl[1].lane[1] = 32'd1;    tbl[1].lane[2] = 32'd2;
    tbl[1].el[0]   = 32'd3;    tbl[1].el[1]   = 32'hFFFF; tbl[1].el[2]   = 32'hFFFF;
    tbl[1].et = 32'hFFFF; tbl[1].es = 16'b110;

    tbl[2].cfg = 2;
    tbl[2].lane[0] = 32'd127; tbl[2].lane[1] = 32'd127; tbl[2].lane[2] = 32'd127;
    tbl[2].lane[3] = 32'hFFFF_FF80;
    tbl[2].el[0] = 32'd126; tbl[2].el[1] = 32'd126; tbl[2].el[2] = 32'd126; tbl[2].el[3] = 32'd127;
    tbl[2].et = 32'd127; tbl[2].es = 16'b1000;

    tbl[3].cfg = 2;
    for (int k = 0; k < 4; k++) begin
      tbl[3].lane[k] = 32'd100;
      tbl[3].el[k]   = 32'd127;
    end
    tbl[3].et = 32'd127; tbl[3].es = 16'b1111;

    tbl[4].cfg = 4;
    tbl[4].lane[0] = 32'd7;         tbl[4].lane[1] = 32'hFFFF_FFF8;
    tbl[4].el[0]   = 32'hFFFF_FFF8; tbl[4].el[1]   = 32'd7;
    tbl[4].et = 32'hFFFF_FFFF; tbl[4].es = 16'h0;

    tbl[5].cfg = 11;
    for (int k = 0; k < 16; k++) begin
      tbl[5].lane[k] = 32'd15;
      tbl[5].el[k]   = 32'd15;
    end
    tbl[5].et = 32'd15; tbl[5].es = 16'hFFFF;

    #2 rst_glob_n = 1'b0;
    #20 rst_glob_n = 1'b1;
    for (int c = 0; c < 60000 && done_vec != '1; c++) @(posedge clk);
    chk("all_done", 0, 512'(done_vec), 512'({NCFG{1'b1}}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
